pio_loader: RTL and testbench

Configuration sequencer that sits directly upstream of `pio` and drives its `action`/`index`/`mindex`/`din` port. On a `start` pulse it streams a program from a synchronous instruction memory into `pio`, then issues that machine's wrap/exec-control, clock-divider, pin-group and enable actions, one action per clock. It replaces hand-sequenced host writes with a fixed, deterministic load sequence.

---
 rtl/pio_loader_if.sv | 46 ++++
 rtl/pio_loader.sv | 211 +++++++++++++++++++++
 tb/tb_pio_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_loader_if.sv
// Bundle between pio_loader, its instruction memory and the downstream pio block.
// master = loader side; slave = host/memory/pio side.
// Optional PIO_LOADER_IMM_EN adds the immediate-instruction request fields.
interface pio_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [1:0]        machine;
  logic [5:0]        plen;
  logic [31:0]       exec_ctrl;
  logic [23:0]       div;
  logic [31:0]       pin_grps;
  logic [3:0]        en_mask;
`ifdef PIO_LOADER_IMM_EN
  logic              imm_req;
  logic [15:0]       imm_instr;
`endif
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [3:0]        action;
  logic [ADDR_W-1:0] index;
  logic [1:0]        mindex;
  logic [31:0]       din;
  logic              busy;
  logic              done;

`ifdef PIO_LOADER_IMM_EN
  modport master (
    input  start, machine, plen, exec_ctrl, div, pin_grps, en_mask, imm_req, imm_instr, prog_data,
    output prog_addr, action, index, mindex, din, busy, done
  );
  modport slave (
    output start, machine, plen, exec_ctrl, div, pin_grps, en_mask, imm_req, imm_instr, prog_data,
    input  prog_addr, action, index, mindex, din, busy, done
  );
`else
  modport master (
    input  start, machine, plen, exec_ctrl, div, pin_grps, en_mask, prog_data,
    output prog_addr, action, index, mindex, din, busy, done
  );
  modport slave (
    output start, machine, plen, exec_ctrl, div, pin_grps, en_mask, prog_data,
    input  prog_addr, action, index, mindex, din, busy, done
  );
`endif
endinterface

// File: rtl/pio_loader.sv
// Streams a program from sync instruction memory into pio, then PEND/DIV/GRPS/EN (opt. IMM), one action per clock.
// Latency: FETCH 1 cycle after start, INSTR k at 2+k, done at 6+plen (7+plen with IMM); outputs registered.
// No backpressure: pio accepts every action; start while busy or in FIN is dropped. Optional: PIO_LOADER_IMM_EN.
module pio_loader #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  pio_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_INSTR, S_PEND, S_DIV, S_GRPS, S_EN, S_IMM, S_FIN
  } state_t;

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
`ifdef PIO_LOADER_IMM_EN
  localparam logic [3:0] A_IMM   = 4'd9;
`endif
  localparam logic [5:0] DEPTH6  = 6'(PROG_DEPTH);
  localparam logic [5:0] LAST6   = 6'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic [5:0]        k_q, k_d;
  logic [5:0]        plen_q, plen_d;
  logic [31:0]       ec_q, ec_d;
  logic [23:0]       div_q, div_d;
  logic [31:0]       grps_q, grps_d;
  logic [3:0]        en_q, en_d;
`ifdef PIO_LOADER_IMM_EN
  logic              imm_req_q, imm_req_d;
  logic [15:0]       imm_instr_q, imm_instr_d;
`endif
  logic [3:0]        action_q, action_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        mindex_q, mindex_d;
  logic [31:0]       din_q, din_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Read address never walks past the last slot, even on a full-depth program.
  function automatic logic [ADDR_W-1:0] sat_addr(input logic [5:0] a);
    return (a > LAST6) ? ADDR_W'(LAST6) : ADDR_W'(a);
  endfunction

  // Next-state, shadow latching and next registered outputs.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    plen_d      = plen_q;
    ec_d        = ec_q;
    div_d       = div_q;
    grps_d      = grps_q;
    en_d        = en_q;
`ifdef PIO_LOADER_IMM_EN
    imm_req_d   = imm_req_q;
    imm_instr_d = imm_instr_q;
`endif
    action_d    = A_NONE;
    index_d     = index_q;
    mindex_d    = mindex_q;
    din_d       = din_q;
    prog_addr_d = prog_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          plen_d      = (bus.plen > DEPTH6) ? DEPTH6 : bus.plen;
          ec_d        = bus.exec_ctrl;
          div_d       = bus.div;
          grps_d      = bus.pin_grps;
          en_d        = bus.en_mask;
`ifdef PIO_LOADER_IMM_EN
          imm_req_d   = bus.imm_req;
          imm_instr_d = bus.imm_instr;
`endif
          mindex_d    = bus.machine;
          prog_addr_d = '0;
          busy_d      = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        k_d = '0;
        if (plen_q != 6'd0) begin
          state_d     = S_INSTR;
          action_d    = A_INSTR;
          index_d     = '0;
          prog_addr_d = sat_addr(6'd1);
        end else begin
          state_d  = S_PEND;
          action_d = A_PEND;
          din_d    = ec_q;
        end
      end
      S_INSTR: begin
        if (k_q == plen_q - 6'd1) begin
          state_d  = S_PEND;
          action_d = A_PEND;
          din_d    = ec_q;
        end else begin
          k_d         = k_q + 6'd1;
          action_d    = A_INSTR;
          index_d     = ADDR_W'(k_q + 6'd1);
          prog_addr_d = sat_addr(k_q + 6'd2);
        end
      end
      S_PEND: begin
        state_d  = S_DIV;
        action_d = A_DIV;
        din_d    = {8'h00, div_q};
      end
      S_DIV: begin
        state_d  = S_GRPS;
        action_d = A_GRPS;
        din_d    = grps_q;
      end
      S_GRPS: begin
        state_d  = S_EN;
        action_d = A_EN;
        din_d    = {28'h0, en_q};
      end
      S_EN: begin
`ifdef PIO_LOADER_IMM_EN
        if (imm_req_q) begin
          state_d  = S_IMM;
          action_d = A_IMM;
          din_d    = {16'h0, imm_instr_q};
        end else begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`else
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
      end
      S_IMM: begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, shadow and output registers; reset aborts any partial load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      plen_q      <= '0;
      ec_q        <= '0;
      div_q       <= '0;
      grps_q      <= '0;
      en_q        <= '0;
`ifdef PIO_LOADER_IMM_EN
      imm_req_q   <= 1'b0;
      imm_instr_q <= '0;
`endif
      action_q    <= A_NONE;
      index_q     <= '0;
      mindex_q    <= '0;
      din_q       <= '0;
      prog_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      plen_q      <= plen_d;
      ec_q        <= ec_d;
      div_q       <= div_d;
      grps_q      <= grps_d;
      en_q        <= en_d;
`ifdef PIO_LOADER_IMM_EN
      imm_req_q   <= imm_req_d;
      imm_instr_q <= imm_instr_d;
`endif
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
      prog_addr_q <= prog_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Memory data arrives straight from the memory's own output register,
  // so INSTR payload bypasses din_q to land in the same cycle as its index.
  assign bus.din       = (action_q == A_INSTR) ? {16'h0, bus.prog_data} : din_q;
  assign bus.action    = action_q;
  assign bus.index     = index_q;
  assign bus.mindex    = mindex_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: sync instruction memory model, cycle-exact action trace checks.
// Cycle 0 = start sampled; checks taken on the falling edge of each cycle.
// Covers reset/idle, normal load, empty and oversize programs, ignored restarts, mid-load reset, IMM.
module tb_pio_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pio_loader_if #(.ADDR_W(5)) bus();

  pio_loader #(.PROG_DEPTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:31];
  always @(posedge clk) bus.prog_data <= mem[bus.prog_addr];

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int poke_cyc = -1;
`ifdef PIO_LOADER_IMM_EN
  bit          exp_imm = 1'b0;
  logic [15:0] exp_immi = 16'h0;
`endif

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one cycle; optionally re-pulse start with scrambled inputs on poke_cyc.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc == poke_cyc) begin
      bus.start     = 1'b1;
      bus.machine   = 2'd2;
      bus.plen      = 6'd5;
      bus.exec_ctrl = 32'hDEADBEEF;
      bus.div       = 24'hFFFFFF;
      bus.pin_grps  = 32'h12345678;
      bus.en_mask   = 4'hF;
    end else begin
      bus.start = 1'b0;
    end
  endtask

  task automatic launch(input logic [5:0] pl, input logic [1:0] m, input logic [31:0] ec,
                        input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] em);
    @(negedge clk);
    bus.plen      = pl;
    bus.machine   = m;
    bus.exec_ctrl = ec;
    bus.div       = dv;
    bus.pin_grps  = pg;
    bus.en_mask   = em;
    bus.start     = 1'b1;
    cyc = 0;
    tick();
  endtask

  // Called at cycle 1; walks the whole sequence for n effective instructions.
  task automatic run_seq(input int n, input logic [1:0] m, input logic [31:0] ec,
                         input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] em);
    check_vec("fetch_busy", 32'(bus.busy), 32'd1);
    check_vec("fetch_action", 32'(bus.action), 32'd0);
    check_vec("fetch_mindex", 32'(bus.mindex), 32'(m));
    check_vec("fetch_prog_addr", 32'(bus.prog_addr), 32'd0);
    for (int k = 0; k < n; k++) begin
      tick();
      check_vec("instr_action", 32'(bus.action), 32'd1);
      check_vec("instr_index", 32'(bus.index), 32'(k));
      check_vec("instr_din", bus.din, {16'h0, mem[k]});
      check_vec("instr_prog_addr", 32'(bus.prog_addr), (k + 1 > 31) ? 32'd31 : 32'(k + 1));
      check_vec("instr_mindex", 32'(bus.mindex), 32'(m));
    end
    tick();
    check_vec("pend_action", 32'(bus.action), 32'd2);
    check_vec("pend_din", bus.din, ec);
    tick();
    check_vec("div_action", 32'(bus.action), 32'd7);
    check_vec("div_din", bus.din, {8'h0, dv});
    tick();
    check_vec("grps_action", 32'(bus.action), 32'd5);
    check_vec("grps_din", bus.din, pg);
    tick();
    check_vec("en_action", 32'(bus.action), 32'd6);
    check_vec("en_din", bus.din, {28'h0, em});
    check_vec("en_busy", 32'(bus.busy), 32'd1);
    check_vec("en_mindex", 32'(bus.mindex), 32'(m));
`ifdef PIO_LOADER_IMM_EN
    if (exp_imm) begin
      tick();
      check_vec("imm_action", 32'(bus.action), 32'd9);
      check_vec("imm_din", bus.din, {16'h0, exp_immi});
      check_vec("imm_done", 32'(bus.done), 32'd0);
    end
`endif
    tick();
    check_vec("fin_done", 32'(bus.done), 32'd1);
    check_vec("fin_busy", 32'(bus.busy), 32'd0);
    check_vec("fin_action", 32'(bus.action), 32'd0);
    check_vec("fin_cycle", 32'(cyc), 32'(n + 6 + ((bus.action == 4'd0) ? imm_extra() : 0)));
    tick();
    check_vec("idle_done", 32'(bus.done), 32'd0);
    check_vec("idle_busy", 32'(bus.busy), 32'd0);
    check_vec("idle_action", 32'(bus.action), 32'd0);
    check_vec("idle_mindex", 32'(bus.mindex), 32'(m));
  endtask

  function automatic int imm_extra();
`ifdef PIO_LOADER_IMM_EN
    return exp_imm ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check_vec({tag, "_action"}, 32'(bus.action), 32'd0);
    check_vec({tag, "_index"}, 32'(bus.index), 32'd0);
    check_vec({tag, "_mindex"}, 32'(bus.mindex), 32'd0);
    check_vec({tag, "_din"}, bus.din, 32'd0);
    check_vec({tag, "_prog_addr"}, 32'(bus.prog_addr), 32'd0);
    check_vec({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_vec({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.machine   = 2'd0;
    bus.plen      = 6'd0;
    bus.exec_ctrl = 32'h0;
    bus.div       = 24'h0;
    bus.pin_grps  = 32'h0;
    bus.en_mask   = 4'h0;
`ifdef PIO_LOADER_IMM_EN
    bus.imm_req   = 1'b0;
    bus.imm_instr = 16'h0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;

    // Reset, then idle ten cycles with no activity.
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.action != 4'd0) seen++;
    end
    check_vec("idle_activity", 32'(seen), 32'd0);
    check_zero("idle10");

    // Two-instruction program, machine 0.
    mem[0] = 16'hE081;
    mem[1] = 16'h0001;
    launch(6'd2, 2'd0, 32'h00001000, 24'h000280, 32'h04000000, 4'h1);
    run_seq(2, 2'd0, 32'h00001000, 24'h000280, 32'h04000000, 4'h1);

    // Empty program, machine 3: straight to PEND.
    launch(6'd0, 2'd3, 32'hA5A5_0001, 24'h123456, 32'h0000_00FF, 4'h8);
    run_seq(0, 2'd3, 32'hA5A5_0001, 24'h123456, 32'h0000_00FF, 4'h8);

    // Oversize program clamps to 32 slots.
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    launch(6'd40, 2'd1, 32'h0000_2000, 24'h00_0100, 32'h0800_0000, 4'h2);
    run_seq(32, 2'd1, 32'h0000_2000, 24'h00_0100, 32'h0800_0000, 4'h2);

    // Restart plus input changes during load are ignored.
    poke_cyc = 3;
    launch(6'd2, 2'd0, 32'h1111_1111, 24'h654321, 32'hCAFE_F00D, 4'h5);
    run_seq(2, 2'd0, 32'h1111_1111, 24'h654321, 32'hCAFE_F00D, 4'h5);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy || bus.action != 4'd0) seen++;
    end
    check_vec("no_queued_start", 32'(seen), 32'd0);

    // Start in the FIN cycle is dropped (plen=1 -> FIN on cycle 7).
    poke_cyc = 7;
    launch(6'd1, 2'd2, 32'h0000_0042, 24'h000003, 32'h0000_0010, 4'h4);
    run_seq(1, 2'd2, 32'h0000_0042, 24'h000003, 32'h0000_0010, 4'h4);
    poke_cyc = -1;

    // Reset asserted on cycle 4 clears outputs immediately, no done.
    launch(6'd2, 2'd1, 32'h0000_7777, 24'h000777, 32'h0000_0777, 4'h7);
    tick();
    tick();
    tick();
    check_vec("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.action != 4'd0) seen++;
    end
    check_vec("no_resume", 32'(seen), 32'd0);

`ifdef PIO_LOADER_IMM_EN
    // Immediate instruction after EN.
    mem[0] = 16'hE081;
    mem[1] = 16'h0001;
    exp_imm  = 1'b1;
    exp_immi = 16'hE001;
    bus.imm_req   = 1'b1;
    bus.imm_instr = 16'hE001;
    launch(6'd2, 2'd0, 32'h00001000, 24'h000280, 32'h04000000, 4'h1);
    bus.imm_req   = 1'b0;
    run_seq(2, 2'd0, 32'h00001000, 24'h000280, 32'h04000000, 4'h1);
    exp_imm = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
